// File: rtl/oam_dma_pkg.sv
// Shared definitions for the sprite DMA engine: FSM encoding, PPU register
// selects and the transfer length.
package oam_dma_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HALT  = 3'd1,
        ST_ALIGN = 3'd2,
        ST_READ  = 3'd3,
        ST_WRITE = 3'd4
    } dma_state_e;

    localparam int DMA_LENGTH = 256;
    localparam logic [7:0] LAST_INDEX = 8'(DMA_LENGTH - 1);

    // PPU register selects, also used by the PPU register bank decode.
    localparam logic [2:0] RS_PPUCTRL   = 3'd0;
    localparam logic [2:0] RS_PPUMASK   = 3'd1;
    localparam logic [2:0] RS_PPUSTATUS = 3'd2;
    localparam logic [2:0] RS_OAMADDR   = 3'd3;
    localparam logic [2:0] RS_OAMDATA   = 3'd4;
    localparam logic [2:0] RS_PPUSCROLL = 3'd5;
    localparam logic [2:0] RS_PPUADDR   = 3'd6;
    localparam logic [2:0] RS_PPUDATA   = 3'd7;

endpackage

// File: rtl/oam_dma.sv
// Sprite DMA: halts the CPU and copies page $P00-$PFF into OAM through OAMDATA writes.
// All state, including the outputs, updates on the falling edge of i_clk.
module oam_dma
    import oam_dma_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_cs_n,
    input  logic        i_rw,
    input  logic [7:0]  i_data,
    output logic        o_cpu_rdy,
    output logic        o_bus_master,
    output logic [15:0] o_address,
    output logic        o_rw,
    output logic        o_ppu_cs_n,
    output logic [2:0]  o_ppu_rs,
    output logic        o_ppu_rw,
    output logic [7:0]  o_ppu_data,
    output logic        o_busy
);

    dma_state_e  state_q, state_d;
    logic [7:0]  page_q, page_d;
    logic [7:0]  index_q, index_d;
    logic [7:0]  latch_q, latch_d;
    logic        odd_q, odd_d;

    logic        cpu_rdy_d, bus_master_d, rw_d, ppu_cs_n_d, ppu_rw_d, busy_d;
    logic [15:0] address_d;
    logic [2:0]  ppu_rs_d;
    logic [7:0]  ppu_data_d;

    always_comb begin
        state_d = state_q;
        page_d  = page_q;
        index_d = index_q;
        latch_d = latch_q;
        odd_d   = ~odd_q;

        case (state_q)
            ST_IDLE: begin
                if (!i_cs_n && !i_rw) begin
                    page_d  = i_data;
                    state_d = ST_HALT;
                end
            end
            // An odd cycle in HALT costs one extra ALIGN cycle before the first read.
            ST_HALT:  state_d = odd_q ? ST_ALIGN : ST_READ;
            ST_ALIGN: state_d = ST_READ;
            ST_READ: begin
                latch_d = i_data;
                state_d = ST_WRITE;
            end
            ST_WRITE: begin
                index_d = index_q + 8'd1;
                state_d = (index_q == LAST_INDEX) ? ST_IDLE : ST_READ;
            end
            default: state_d = ST_IDLE;
        endcase

        // Outputs are decoded from the next state so they register alongside it.
        cpu_rdy_d    = (state_d == ST_IDLE);
        busy_d       = (state_d != ST_IDLE);
        bus_master_d = (state_d == ST_READ) || (state_d == ST_WRITE);
        address_d    = (state_d == ST_READ) ? {page_d, index_d} : 16'h0000;
        rw_d         = 1'b1;
        ppu_cs_n_d   = (state_d != ST_WRITE);
        ppu_rs_d     = (state_d == ST_WRITE) ? RS_OAMDATA : 3'd0;
        ppu_rw_d     = (state_d != ST_WRITE);
        ppu_data_d   = (state_d == ST_WRITE) ? latch_d : 8'h00;
    end

    always_ff @(negedge i_clk) begin
        if (i_reset) begin
            state_q      <= ST_IDLE;
            page_q       <= 8'h00;
            index_q      <= 8'h00;
            latch_q      <= 8'h00;
            odd_q        <= 1'b0;
            o_cpu_rdy    <= 1'b1;
            o_bus_master <= 1'b0;
            o_address    <= 16'h0000;
            o_rw         <= 1'b1;
            o_ppu_cs_n   <= 1'b1;
            o_ppu_rs     <= 3'd0;
            o_ppu_rw     <= 1'b1;
            o_ppu_data   <= 8'h00;
            o_busy       <= 1'b0;
        end else begin
            state_q      <= state_d;
            page_q       <= page_d;
            index_q      <= index_d;
            latch_q      <= latch_d;
            odd_q        <= odd_d;
            o_cpu_rdy    <= cpu_rdy_d;
            o_bus_master <= bus_master_d;
            o_address    <= address_d;
            o_rw         <= rw_d;
            o_ppu_cs_n   <= ppu_cs_n_d;
            o_ppu_rs     <= ppu_rs_d;
            o_ppu_rw     <= ppu_rw_d;
            o_ppu_data   <= ppu_data_d;
            o_busy       <= busy_d;
        end
    end

endmodule

// File: tb/tb_oam_dma.sv
// Self-checking bench for oam_dma: DUT updates on the falling edge, the bench
// samples and drives at the rising edge.
module tb_oam_dma;

    logic        clk;
    logic        reset;
    logic        cs_n;
    logic        rw;
    logic [7:0]  data;
    logic        o_cpu_rdy, o_bus_master, o_rw, o_ppu_cs_n, o_ppu_rw, o_busy;
    logic [15:0] o_address;
    logic [2:0]  o_ppu_rs;
    logic [7:0]  o_ppu_data;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int busy_cnt = 0;
    int bad_attr = 0;
    int bad_idle = 0;
    int trig_par = 0;
    logic [15:0] rd_q[$];
    logic [7:0]  wr_q[$];

    oam_dma dut (
        .i_clk(clk), .i_reset(reset), .i_cs_n(cs_n), .i_rw(rw), .i_data(data),
        .o_cpu_rdy(o_cpu_rdy), .o_bus_master(o_bus_master), .o_address(o_address),
        .o_rw(o_rw), .o_ppu_cs_n(o_ppu_cs_n), .o_ppu_rs(o_ppu_rs), .o_ppu_rw(o_ppu_rw),
        .o_ppu_data(o_ppu_data), .o_busy(o_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // CPU memory contents seen by the DMA.
    function automatic logic [7:0] mem(input logic [15:0] a);
        return a[7:0] ^ 8'h5A;
    endfunction

    // Reference: a transfer of page P reads P00..PFF in order and writes mem() of each.
    function automatic int model_diffs(input logic [7:0] page);
        int d = 0;
        logic [15:0] exp_addr;
        if (rd_q.size() != 256 || wr_q.size() != 256) return 999;
        for (int i = 0; i < 256; i++) begin
            exp_addr = {page, 8'(i)};
            if (rd_q[i] !== exp_addr) d++;
            if (wr_q[i] !== mem(exp_addr)) d++;
        end
        return d;
    endfunction

    // Busy spans HALT, an optional ALIGN and 256 read/write pairs.
    function automatic int model_len(input int par_at_trigger);
        return 1 + ((par_at_trigger == 0) ? 1 : 0) + 2 * 256;
    endfunction

    // One bus cycle: sample at the rising edge, record activity, serve read data.
    task automatic cycle();
        @(posedge clk);
        cyc++;
        if (o_busy === 1'b1) busy_cnt++;
        if (o_bus_master === 1'b1 && o_rw === 1'b1 && o_ppu_cs_n === 1'b1) begin
            rd_q.push_back(o_address);
            data = mem(o_address);
        end
        if (o_ppu_cs_n === 1'b0) begin
            wr_q.push_back(o_ppu_data);
            if (o_ppu_rs !== 3'd4 || o_ppu_rw !== 1'b0 || o_bus_master !== 1'b1) bad_attr++;
        end
        if (o_busy === 1'b0 && (o_bus_master !== 1'b0 || o_ppu_cs_n !== 1'b1 || o_cpu_rdy !== 1'b1))
            bad_idle++;
    endtask

    task automatic clear_obs();
        rd_q.delete();
        wr_q.delete();
        busy_cnt = 0;
        bad_attr = 0;
        bad_idle = 0;
    endtask

    task automatic do_reset();
        reset = 1'b1; cs_n = 1'b1; rw = 1'b1; data = 8'h00;
        repeat (2) cycle();
        reset = 1'b0;
        cyc = 0;
        clear_obs();
    endtask

    task automatic trigger(input logic [7:0] page);
        clear_obs();
        cycle();
        cs_n = 1'b0; rw = 1'b0; data = page;
        trig_par = cyc % 2;
        cycle();
        cs_n = 1'b1; rw = 1'b1;
    endtask

    // Runs until busy drops, with optional retrigger / reset injection points.
    task automatic run_transfer(input int retrig_at, input bit trig_last, input int rst_write);
        bit done = 1'b0;
        for (int n = 0; n < 700 && !done; n++) begin
            cycle();
            cs_n = 1'b1; rw = 1'b1;
            if (o_busy !== 1'b1) done = 1'b1;
            else if (rst_write != 0 && o_ppu_cs_n === 1'b0 && wr_q.size() == rst_write) begin
                reset = 1'b1;
                done = 1'b1;
            end else if (retrig_at != 0 && busy_cnt == retrig_at) begin
                cs_n = 1'b0; rw = 1'b0; data = 8'h07;
            end else if (trig_last && o_ppu_cs_n === 1'b0 && wr_q.size() == 256) begin
                cs_n = 1'b0; rw = 1'b0; data = 8'h11;
            end
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL timeout: busy still %b after 700 cycles, required 0", o_busy);
        end
    endtask

    task automatic check_transfer(input string name, input logic [7:0] page);
        int diffs;
        checks++;
        if (busy_cnt != model_len(trig_par)) begin
            errors++;
            $display("FAIL %s_len: busy %0d cycles, required %0d", name, busy_cnt, model_len(trig_par));
        end
        diffs = model_diffs(page);
        checks++;
        if (diffs != 0) begin
            errors++;
            $display("FAIL %s_data: %0d reads %0d writes %0d diffs, required 256/256/0",
                     name, rd_q.size(), wr_q.size(), diffs);
        end
        checks++;
        if (bad_attr != 0 || bad_idle != 0) begin
            errors++;
            $display("FAIL %s_ctrl: bad_attr %0d bad_idle %0d, required 0/0", name, bad_attr, bad_idle);
        end
        checks++;
        if (o_cpu_rdy !== 1'b1 || o_bus_master !== 1'b0) begin
            errors++;
            $display("FAIL %s_end: rdy %b master %b, required 1/0", name, o_cpu_rdy, o_bus_master);
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({o_cpu_rdy, o_bus_master, o_rw, o_ppu_cs_n, o_ppu_rw, o_busy} !== 6'b101110 ||
            o_address !== 16'h0000 || o_ppu_rs !== 3'd0 || o_ppu_data !== 8'h00) begin
            errors++;
            $display("FAIL reset: rdy %b mst %b rw %b cs_n %b prw %b busy %b addr %h rs %0d pdata %h, required 1 0 1 1 1 0 0000 0 00",
                     o_cpu_rdy, o_bus_master, o_rw, o_ppu_cs_n, o_ppu_rw, o_busy, o_address, o_ppu_rs, o_ppu_data);
        end
    endtask

    task automatic test_even();
        do_reset();
        trigger(8'h02);
        run_transfer(0, 1'b0, 0);
        check_transfer("even", 8'h02);
    endtask

    task automatic test_odd();
        do_reset();
        cycle();
        trigger(8'h02);
        run_transfer(0, 1'b0, 0);
        check_transfer("odd", 8'h02);
    endtask

    task automatic test_retrigger();
        do_reset();
        cycle();
        trigger(8'h02);
        run_transfer(100, 1'b0, 0);
        check_transfer("retrig", 8'h02);
    endtask

    task automatic test_page_ff();
        do_reset();
        repeat ($urandom_range(0, 3)) cycle();
        trigger(8'hFF);
        run_transfer(0, 1'b1, 0);
        check_transfer("page_ff", 8'hFF);
        clear_obs();
        repeat (3) cycle();
        checks++;
        if (busy_cnt != 0 || rd_q.size() != 0) begin
            errors++;
            $display("FAIL last_write_trigger: busy %0d cycles reads %0d, required 0/0", busy_cnt, rd_q.size());
        end
        // Next transfer must start at index 0 after the wrap.
        trigger(8'h40);
        run_transfer(0, 1'b0, 0);
        check_transfer("after_wrap", 8'h40);
    endtask

    task automatic test_reset_mid();
        do_reset();
        trigger(8'h02);
        run_transfer(0, 1'b0, 41);
        cycle();
        checks++;
        if (o_ppu_cs_n !== 1'b1 || o_busy !== 1'b0 || o_cpu_rdy !== 1'b1 || o_bus_master !== 1'b0 ||
            o_address !== 16'h0000 || o_ppu_data !== 8'h00 || o_ppu_rw !== 1'b1 || o_ppu_rs !== 3'd0) begin
            errors++;
            $display("FAIL reset_mid_out: cs_n %b busy %b rdy %b mst %b addr %h, required 1 0 1 0 0000",
                     o_ppu_cs_n, o_busy, o_cpu_rdy, o_bus_master, o_address);
        end
        reset = 1'b0;
        cyc = 0;
        repeat (3) cycle();
        checks++;
        if (wr_q.size() != 41) begin
            errors++;
            $display("FAIL reset_mid_writes: %0d writes, required 41", wr_q.size());
        end
        trigger(8'h03);
        run_transfer(0, 1'b0, 0);
        check_transfer("after_reset", 8'h03);
    endtask

    task automatic test_read_trigger();
        do_reset();
        cycle();
        cs_n = 1'b0; rw = 1'b1; data = 8'h09;
        repeat (4) cycle();
        cs_n = 1'b1;
        repeat (2) cycle();
        checks++;
        if (busy_cnt != 0 || rd_q.size() != 0 || wr_q.size() != 0 || bad_idle != 0) begin
            errors++;
            $display("FAIL read_trigger: busy %0d reads %0d writes %0d bad_idle %0d, required 0",
                     busy_cnt, rd_q.size(), wr_q.size(), bad_idle);
        end
    endtask

    task automatic test_random();
        logic [7:0] page;
        do_reset();
        for (int t = 0; t < 4; t++) begin
            repeat ($urandom_range(0, 5)) cycle();
            page = 8'($urandom_range(0, 255));
            trigger(page);
            run_transfer(0, 1'b0, 0);
            check_transfer("random", page);
        end
    endtask

    initial begin
        reset = 1'b1; cs_n = 1'b1; rw = 1'b1; data = 8'h00;
        test_reset();
        test_even();
        test_odd();
        test_retrigger();
        test_page_ff();
        test_reset_mid();
        test_read_trigger();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
